// File: rtl/serial_tx_pkg.sv
// Shared types and line levels for the serial frame transmitter.
package serial_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Counter width for a modulo-n count, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_tx_lin_dff.sv
// Linear storage cells: 1-bit async-reset flop with load enable, and a 1-to-2 fanout split.
// Flop output has exactly one consumer; any further fanout goes through split.
module dff_ar_lin #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_en,
  input  logic i_d,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= RST_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

module split (
  input  logic i_a,
  output logic o_b,
  output logic o_c
);

  assign o_b = i_a;
  assign o_c = i_a;

endmodule

// File: rtl/serial_tx_lin.sv
// Framed serial transmitter (start, WIDTH data bits LSB first, stop); frame is (WIDTH+2)*CLKS_PER_BIT cycles, all outputs registered.
// One word accepted per frame on valid/ready; i_ready is high only in IDLE, upstream holds i_valid while busy.
module serial_tx_lin
  import serial_tx_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             i_ready,
  output logic             o_serial,
  output logic             o_frame,
  output logic             o_done
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam int BW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  logic [1:0]       w_state_q;
  logic [1:0]       w_state_nsl;
  logic [1:0]       w_state_out;
  logic [1:0]       w_state_d_bits;
  tx_state_t        w_state;
  tx_state_t        w_state_d;
  logic [CW-1:0]    w_cyc_q;
  logic [CW-1:0]    w_cyc_d;
  logic [BW-1:0]    w_bit_q;
  logic [BW-1:0]    w_bit_d;
  logic [WIDTH-1:0] w_shreg_q;
  logic [WIDTH-1:0] w_shreg_d;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic             w_shreg_en;
  logic             w_cyc_last;
  logic             w_ready_q;
  logic             w_ready_acc;
  logic             w_ready_d;
  logic             w_serial_d;
  logic             w_frame_d;
  logic             w_done_d;

  assign w_state    = tx_state_t'(w_state_nsl);
  assign w_cyc_last = (w_cyc_q == CYC_LAST);

  always_comb begin
    w_state_d  = w_state;
    w_cyc_d    = w_cyc_q;
    w_bit_d    = w_bit_q;
    w_shreg_en = 1'b0;
    w_shreg_d  = w_shreg_q >> 1;
    case (w_state)
      IDLE: begin
        if (i_valid && w_ready_acc) begin
          w_state_d  = START;
          w_shreg_en = 1'b1;
          w_shreg_d  = i_data;
          w_cyc_d    = '0;
          w_bit_d    = '0;
        end
      end
      START: begin
        w_cyc_d = w_cyc_q + 1'b1;
        if (w_cyc_last) begin
          w_cyc_d   = '0;
          w_state_d = DATA;
        end
      end
      DATA: begin
        w_cyc_d = w_cyc_q + 1'b1;
        if (w_cyc_last) begin
          w_cyc_d    = '0;
          w_shreg_en = 1'b1;
          if (w_bit_q == BIT_LAST) begin
            w_bit_d   = '0;
            w_state_d = STOP;
          end else begin
            w_bit_d = w_bit_q + 1'b1;
          end
        end
      end
      STOP: begin
        w_cyc_d = w_cyc_q + 1'b1;
        if (w_cyc_last) begin
          w_cyc_d   = '0;
          w_state_d = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  assign w_shreg_nxt    = w_shreg_en ? w_shreg_d : w_shreg_q;
  assign w_state_d_bits = w_state_d;

  // Outputs are decoded from the next state so they line up with it after the edge.
  always_comb begin
    w_serial_d = LINE_IDLE;
    case (w_state_d)
      START:   w_serial_d = START_BIT;
      DATA:    w_serial_d = w_shreg_nxt[0];
      STOP:    w_serial_d = STOP_BIT;
      default: w_serial_d = LINE_IDLE;
    endcase
    w_frame_d = (w_state_d != IDLE);
    w_ready_d = (w_state_d == IDLE);
    w_done_d  = (tx_state_t'(w_state_out) == STOP) && (w_state_d == IDLE);
  end

  for (genvar g = 0; g < 2; g++) begin : gen_state
    dff_ar_lin #(.RST_VAL(1'b0)) u_ff (
      .clock, .reset_n, .i_en(1'b1), .i_d(w_state_d_bits[g]), .o_q(w_state_q[g])
    );
    split u_split (.i_a(w_state_q[g]), .o_b(w_state_nsl[g]), .o_c(w_state_out[g]));
  end

  for (genvar g = 0; g < CW; g++) begin : gen_cyc
    dff_ar_lin #(.RST_VAL(1'b0)) u_ff (
      .clock, .reset_n, .i_en(1'b1), .i_d(w_cyc_d[g]), .o_q(w_cyc_q[g])
    );
  end

  for (genvar g = 0; g < BW; g++) begin : gen_bit
    dff_ar_lin #(.RST_VAL(1'b0)) u_ff (
      .clock, .reset_n, .i_en(1'b1), .i_d(w_bit_d[g]), .o_q(w_bit_q[g])
    );
  end

  for (genvar g = 0; g < WIDTH; g++) begin : gen_shreg
    dff_ar_lin #(.RST_VAL(1'b0)) u_ff (
      .clock, .reset_n, .i_en(w_shreg_en), .i_d(w_shreg_d[g]), .o_q(w_shreg_q[g])
    );
  end

  dff_ar_lin #(.RST_VAL(1'b1)) u_ready_ff (
    .clock, .reset_n, .i_en(1'b1), .i_d(w_ready_d), .o_q(w_ready_q)
  );
  split u_ready_split (.i_a(w_ready_q), .o_b(i_ready), .o_c(w_ready_acc));

  dff_ar_lin #(.RST_VAL(LINE_IDLE)) u_serial_ff (
    .clock, .reset_n, .i_en(1'b1), .i_d(w_serial_d), .o_q(o_serial)
  );
  dff_ar_lin #(.RST_VAL(1'b0)) u_frame_ff (
    .clock, .reset_n, .i_en(1'b1), .i_d(w_frame_d), .o_q(o_frame)
  );
  dff_ar_lin #(.RST_VAL(1'b0)) u_done_ff (
    .clock, .reset_n, .i_en(1'b1), .i_d(w_done_d), .o_q(o_done)
  );

endmodule

// File: tb/tb_serial_tx_lin.sv
// Bench for serial_tx_lin: frame tables, hand-written corner sequences and random traffic against a timing model.
module tb_serial_tx_lin;

  localparam int W  = 8;
  localparam int C  = 4;
  localparam int FR = (W + 2) * C;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] i_data  = '0;
  logic       i_valid = 1'b0;
  logic       i_ready, o_serial, o_frame, o_done;

  logic [0:0] d1_data  = '0;
  logic       d1_valid = 1'b0;
  logic       d1_ready, d1_serial, d1_frame, d1_done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  bit         m_active = 0;
  bit         m_done   = 0;
  int         m_t      = 0;
  logic [7:0] m_data   = '0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] pat;
  } vec_t;
  vec_t vecs[5];

  serial_tx_lin #(.WIDTH(W), .CLKS_PER_BIT(C)) dut (
    .clock(clock), .reset_n(reset_n), .i_data(i_data), .i_valid(i_valid),
    .i_ready(i_ready), .o_serial(o_serial), .o_frame(o_frame), .o_done(o_done)
  );

  serial_tx_lin #(.WIDTH(1), .CLKS_PER_BIT(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .i_data(d1_data), .i_valid(d1_valid),
    .i_ready(d1_ready), .o_serial(d1_serial), .o_frame(d1_frame), .o_done(d1_done)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line level t cycles after the accept edge of the word m_data.
  function automatic logic exp_line(input int t);
    if (t < C) return 1'b0;
    if (t < (W + 1) * C) return m_data[t / C - 1];
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_active = 0;
    m_done   = 0;
    m_t      = 0;
  endtask

  task automatic step();
    @(posedge clock);
    if (m_active) begin
      m_t++;
      if (m_t == FR) begin
        m_active = 0;
        m_done   = 1;
      end else begin
        m_done = 0;
      end
    end else begin
      m_done = 0;
      if (i_valid) begin
        m_active = 1;
        m_t      = 0;
        m_data   = i_data;
      end
    end
    cyc++;
    #1;
    chk("model_serial", o_serial, m_active ? exp_line(m_t) : 1'b1);
    chk("model_frame", o_frame, m_active);
    chk("model_ready", i_ready, !m_active);
    chk("model_done", o_done, m_done);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!i_ready && n < 100) begin
      step();
      n++;
    end
    chk("wait_ready_timeout", i_ready, 1);
  endtask

  task automatic async_reset_check(input string name);
    #2 reset_n = 1'b0;
    #1;
    chk({name, "_serial"}, o_serial, 1);
    chk({name, "_frame"}, o_frame, 0);
    chk({name, "_ready"}, i_ready, 1);
    chk({name, "_done"}, o_done, 0);
    model_reset();
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 10'b0101001011};
    vecs[1] = '{8'h3C, 10'b0001111001};
    vecs[2] = '{8'h00, 10'b0000000001};
    vecs[3] = '{8'hFF, 10'b0111111111};
    vecs[4] = '{8'h5A, 10'b0010110101};

    // Reset held for three edges, then released with no traffic.
    #1 reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
      chk("rst_serial", o_serial, 1);
      chk("rst_ready", i_ready, 1);
      chk("rst_frame", o_frame, 0);
      chk("rst_done", o_done, 0);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) step();

    // Table: each word's line pattern, one symbol per C cycles, then the done pulse.
    for (int v = 0; v < 5; v++) begin
      wait_ready();
      i_valid = 1'b1;
      i_data  = vecs[v].data;
      step();
      i_valid = 1'b0;
      i_data  = 8'($urandom);
      for (int t = 0; t < FR; t++) begin
        if (t > 0) step();
        chk("table_line", o_serial, vecs[v].pat[9 - t / C]);
        chk("table_frame", o_frame, 1);
      end
      step();
      chk("table_done", o_done, 1);
      chk("table_done_ready", i_ready, 1);
      step();
      chk("table_done_once", o_done, 0);
    end

    // Busy: i_valid and new data held throughout the 8'h3C frame.
    wait_ready();
    i_valid = 1'b1;
    i_data  = 8'h3C;
    step();
    i_data = 8'hFF;
    for (int t = 0; t < FR; t++) begin
      if (t > 0) step();
      chk("busy_ready_low", i_ready, 0);
      chk("busy_line", o_serial, vecs[1].pat[9 - t / C]);
    end
    step();
    chk("busy_done", o_done, 1);
    chk("busy_ready_high", i_ready, 1);
    step();
    i_valid = 1'b0;
    chk("busy_second_start", o_serial, 0);
    chk("busy_second_frame", o_frame, 1);
    wait_ready();

    // Back-to-back: the done cycle doubles as the next accept cycle.
    begin
      int t0, d1c, d2c, nd;
      bit drop;
      nd = 0; d1c = 0; d2c = 0; drop = 0;
      i_valid = 1'b1;
      i_data  = 8'h00;
      step();
      t0 = cyc;
      i_data = 8'hFF;
      for (int k = 0; k < 200 && nd < 2; k++) begin
        step();
        if (drop) begin
          i_valid = 1'b0;
          drop    = 0;
          chk("b2b_no_gap_start", o_serial, 0);
        end
        if (o_done) begin
          nd++;
          if (nd == 1) begin
            d1c  = cyc;
            drop = 1;
          end else begin
            d2c = cyc;
          end
        end
      end
      i_valid = 1'b0;
      chk("b2b_done_count", nd, 2);
      chk("b2b_first_done", d1c - t0, FR);
      chk("b2b_second_done", d2c - d1c, FR + 1);
    end

    // Reset during data bit 3 of 8'h5A: frame dropped, no done afterwards.
    wait_ready();
    i_valid = 1'b1;
    i_data  = 8'h5A;
    step();
    i_valid = 1'b0;
    for (int k = 0; k < 4 * C + 1; k++) step();
    chk("mid_in_frame", o_frame, 1);
    async_reset_check("mid_rst");
    begin
      int seen = 0;
      for (int k = 0; k < FR + 5; k++) begin
        step();
        seen = seen | int'(o_done);
      end
      chk("mid_no_done", seen, 0);
      chk("mid_ready", i_ready, 1);
    end

    // WIDTH=1, C=1 instance: 0,1,1 then done.
    chk("w1_ready", d1_ready, 1);
    d1_valid = 1'b1;
    d1_data  = 1'b1;
    step();
    d1_valid = 1'b0;
    chk("w1_start", d1_serial, 0);
    chk("w1_frame", d1_frame, 1);
    chk("w1_busy", d1_ready, 0);
    step();
    chk("w1_data", d1_serial, 1);
    step();
    chk("w1_stop", d1_serial, 1);
    chk("w1_stop_frame", d1_frame, 1);
    chk("w1_stop_nodone", d1_done, 0);
    step();
    chk("w1_done", d1_done, 1);
    chk("w1_idle_frame", d1_frame, 0);
    chk("w1_idle_ready", d1_ready, 1);
    step();
    chk("w1_done_once", d1_done, 0);

    // Random traffic with occasional asynchronous resets.
    for (int k = 0; k < 1500; k++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_data  = 8'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        async_reset_check("rand_rst");
      end else begin
        step();
      end
    end
    i_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
